// File: rtl/traffic_pkg.sv
// Shared definitions for the main/branch intersection controller.
// - phase_t and the St* constants: 4-bit phase encoding, also visible on the phase output.
// - Lamp* constants: one-hot lamp words, main {L,R,Y,G} and branch {R,Y,G}.
// - Lane* constants: bit index of each lane inside the load_l/load_h vectors.
// - decode_lamps(): the lamp/walk pattern shown for a given phase.
package traffic_pkg;

  typedef logic [3:0] phase_t;

  localparam phase_t StMainG   = 4'd0;
  localparam phase_t StMainY1  = 4'd1;
  localparam phase_t StLeft    = 4'd2;
  localparam phase_t StMainY2  = 4'd3;
  localparam phase_t StArM     = 4'd4;
  localparam phase_t StBrG     = 4'd5;
  localparam phase_t StBrY     = 4'd6;
  localparam phase_t StArB     = 4'd7;
  localparam phase_t StPreempt = 4'd8;

  localparam logic [3:0] LampMainG  = 4'b0001;
  localparam logic [3:0] LampMainY  = 4'b0010;
  localparam logic [3:0] LampMainLR = 4'b1100;
  localparam logic [3:0] LampMainR  = 4'b0100;
  localparam logic [2:0] LampBrR    = 3'b100;
  localparam logic [2:0] LampBrY    = 3'b010;
  localparam logic [2:0] LampBrG    = 3'b001;

  localparam int unsigned LaneMain = 0;
  localparam int unsigned LaneLeft = 1;
  localparam int unsigned LaneBr   = 2;

  typedef struct packed {
    logic [3:0] main_lryg;
    logic [2:0] br_ryg;
    logic       ped_walk;
  } lamps_t;

  // All-red is the fallback so an unknown phase never shows a green.
  function automatic lamps_t decode_lamps(phase_t ph);
    lamps_t l;
    l.main_lryg = LampMainR;
    l.br_ryg    = LampBrR;
    l.ped_walk  = 1'b0;
    case (ph)
      StMainG, StPreempt: l.main_lryg = LampMainG;
      StMainY1, StMainY2: l.main_lryg = LampMainY;
      StLeft:             l.main_lryg = LampMainLR;
      StBrG: begin
        l.br_ryg   = LampBrG;
        l.ped_walk = 1'b1;
      end
      StBrY:              l.br_ryg = LampBrY;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Sensor/timebase inputs and lamp-driver outputs of traffic_phase_ctrl.
// - master: the environment (sensors, timebase, lamp drivers).
// - slave:  the controller.
// Signals: tick, load_l[2:0], load_h[2:0], ped_req, preempt (to controller);
//          main_lryg[3:0], br_ryg[2:0], phase[3:0], remaining[TW-1:0], ped_walk (from it).
interface traffic_phase_ctrl_if #(
  parameter int unsigned TW = 5
);

  logic          tick;
  logic [2:0]    load_l;
  logic [2:0]    load_h;
  logic          ped_req;
  logic          preempt;
  logic [3:0]    main_lryg;
  logic [2:0]    br_ryg;
  logic [3:0]    phase;
  logic [TW-1:0] remaining;
  logic          ped_walk;

  modport master (
    output tick, load_l, load_h, ped_req, preempt,
    input  main_lryg, br_ryg, phase, remaining, ped_walk
  );

  modport slave (
    input  tick, load_l, load_h, ped_req, preempt,
    output main_lryg, br_ryg, phase, remaining, ped_walk
  );

endinterface

// File: rtl/phase_timer.sv
// Down-counter holding the ticks left in the current phase.
// Ports:
// - clk       : system clock
// - load      : load load_val this edge (wins over tick)
// - load_val  : phase duration to load
// - tick      : timebase strobe; decrements remaining
// - remaining : ticks left, registered
// - done      : last tick of the phase (tick && remaining == 1)
// There is no reset input: the owner asserts load with the reset duration while in reset.
module phase_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] remaining,
  output logic          done
);

  logic [TW-1:0] remaining_q;

  always_ff @(posedge clk) begin
    if (load) begin
      remaining_q <= load_val;
    end else if (tick) begin
      remaining_q <= remaining_q - TW'(1);
    end
  end

  assign remaining = remaining_q;
  assign done      = tick && (remaining_q == TW'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main/branch intersection controller with integrated phase timer, green extension under heavy
// load, latched pedestrian request, all-red clearance and emergency preemption.
// Ports:
// - clk   : system clock
// - reset : synchronous, active-high; dominates every other input
// - bus   : traffic_phase_ctrl_if.slave
//           in : tick, load_l/load_h ([0] main, [1] left, [2] branch), ped_req, preempt
//           out: main_lryg, br_ryg, ped_walk (registered, one cycle after the phase change),
//                phase, remaining
module traffic_phase_ctrl #(
  parameter int unsigned TW       = 5,
  parameter int unsigned T_MAIN_G = 20,
  parameter int unsigned T_YEL    = 3,
  parameter int unsigned T_LEFT   = 10,
  parameter int unsigned T_BR_G   = 15,
  parameter int unsigned T_EXT    = 5,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned MAX_EXT  = 2
) (
  input  logic                clk,
  input  logic                reset,
  traffic_phase_ctrl_if.slave bus
);

  import traffic_pkg::*;

  localparam int unsigned   EW        = $clog2(MAX_EXT + 2);
  localparam logic [EW-1:0] ExtMax    = EW'(MAX_EXT);
  localparam logic [TW-1:0] DurMainG  = TW'(T_MAIN_G);
  localparam logic [TW-1:0] DurYel    = TW'(T_YEL);
  localparam logic [TW-1:0] DurLeft   = TW'(T_LEFT);
  localparam logic [TW-1:0] DurBrG    = TW'(T_BR_G);
  localparam logic [TW-1:0] DurExt    = TW'(T_EXT);
  localparam logic [TW-1:0] DurAllRed = TW'(T_ALLRED);

  phase_t        state_q, state_d;
  logic [EW-1:0] ext_q, ext_d;
  logic          ped_lat_q, ped_lat_d;
  logic          pre_lat_q, pre_lat_d;
  lamps_t        lamps_q;

  logic          tmr_load, tmr_tick, tmr_done;
  logic [TW-1:0] tmr_load_val, remaining, entry_dur, reload_val;
  logic          reload;
  logic          demand_br, demand_left, can_extend, enter_br_g;
  logic          unused_load_l_main;

  assign demand_br   = bus.load_l[LaneBr] | bus.load_h[LaneBr] | ped_lat_q;
  assign demand_left = bus.load_l[LaneLeft] | bus.load_h[LaneLeft];
  assign can_extend  = ext_q < ExtMax;
  assign enter_br_g  = (state_d == StBrG) && (state_q != StBrG);

  // Light main-through traffic does not influence any decision.
  assign unused_load_l_main = bus.load_l[LaneMain];

  // The phase clock is frozen while preempted.
  assign tmr_tick = bus.tick && (state_q != StPreempt);

  phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .remaining(remaining),
    .done     (tmr_done)
  );

  // Next phase. Preempt truncation is tested before phase end, so it beats both the normal
  // transition and any extension decided on the same edge.
  always_comb begin
    state_d    = state_q;
    ext_d      = ext_q;
    reload     = 1'b0;
    reload_val = DurMainG;
    case (state_q)
      StMainG: begin
        if (bus.preempt) begin
          state_d = StPreempt;
        end else if (tmr_done) begin
          if (!demand_br) begin
            reload = 1'b1;  // nobody waiting: rest in green
          end else if (bus.load_h[LaneMain] && can_extend) begin
            reload     = 1'b1;
            reload_val = DurExt;
            ext_d      = ext_q + EW'(1);
          end else begin
            state_d = StMainY1;
          end
        end
      end
      StMainY1: if (tmr_done) state_d = demand_left ? StLeft : StArM;
      StLeft:   if (bus.preempt || tmr_done) state_d = StMainY2;
      StMainY2: if (tmr_done) state_d = StArM;
      StArM:    if (tmr_done) state_d = pre_lat_q ? StPreempt : StBrG;
      StBrG: begin
        if (bus.preempt) begin
          state_d = StBrY;
        end else if (tmr_done) begin
          if (bus.load_h[LaneBr] && can_extend) begin
            reload     = 1'b1;
            reload_val = DurExt;
            ext_d      = ext_q + EW'(1);
          end else begin
            state_d = StBrY;
          end
        end
      end
      StBrY:     if (tmr_done) state_d = StArB;
      StArB:     if (tmr_done) state_d = pre_lat_q ? StPreempt : StMainG;
      StPreempt: if (!bus.preempt) state_d = StMainG;
      default:   state_d = StArM;
    endcase
    if (state_d != state_q) ext_d = '0;
  end

  // Duration loaded on entry to state_d.
  always_comb begin
    case (state_d)
      StMainG:                   entry_dur = DurMainG;
      StMainY1, StMainY2, StBrY: entry_dur = DurYel;
      StLeft:                    entry_dur = DurLeft;
      StBrG:                     entry_dur = DurBrG;
      StPreempt:                 entry_dur = '0;
      default:                   entry_dur = DurAllRed;
    endcase
  end

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = entry_dur;
    if (reset) begin
      tmr_load     = 1'b1;
      tmr_load_val = DurMainG;
    end else if (state_d != state_q) begin
      tmr_load = 1'b1;
    end else if (reload) begin
      tmr_load     = 1'b1;
      tmr_load_val = reload_val;
    end
  end

  // A request arriving on the BR_G entry edge is kept for the next branch phase.
  assign ped_lat_d = bus.ped_req | (ped_lat_q & ~enter_br_g);
  // Held low throughout preemption so a still-asserted preempt does not re-arm it on exit.
  assign pre_lat_d = (state_d == StPreempt) ? 1'b0 : (pre_lat_q | bus.preempt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StMainG;
      ext_q     <= '0;
      ped_lat_q <= 1'b0;
      pre_lat_q <= 1'b0;
      lamps_q   <= decode_lamps(StMainG);
    end else begin
      state_q   <= state_d;
      ext_q     <= ext_d;
      ped_lat_q <= ped_lat_d;
      pre_lat_q <= pre_lat_d;
      lamps_q   <= decode_lamps(state_q);
    end
  end

  assign bus.main_lryg = lamps_q.main_lryg;
  assign bus.br_ryg    = lamps_q.br_ryg;
  assign bus.ped_walk  = lamps_q.ped_walk;
  assign bus.phase     = state_q;
  assign bus.remaining = remaining;

endmodule
